// File: rtl/mux_arb_4.sv
// mux_arb_4: round-robin 4:1 mux with one output register and valid/ready handshake; optional burst mode via MUX_ARB_BURST_EN
module mux_arb_4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic         out_ready,
    output logic [3:0]   gnt,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state_q, state_d;
    logic [1:0] ptr_q, ptr_d, out_sel_q, out_sel_d, pick, idx;
    logic [W-1:0] out_data_q, out_data_d, mux_d;
    logic can_load, found, load;
`ifdef MUX_ARB_BURST_EN
    logic [1:0] cnt_q, cnt_d;
    logic burst_q, burst_d;
`endif
    assign can_load  = (state_q == EMPTY) || out_ready;
    assign load      = !rst && can_load && found;
    assign gnt       = load ? (4'b0001 << pick) : 4'b0000;
    assign mux_d     = pick[1] ? (pick[0] ? d3 : d2) : (pick[0] ? d1 : d0);
    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    // pick the winner: burst re-grant of the last index first, else search ptr+1..ptr+4
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
`ifdef MUX_ARB_BURST_EN
        if (burst_q && req[ptr_q] && cnt_q != 2'd3) found = 1'b1;
`endif
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end
    // next state: load on grant, drain to EMPTY when the consumer takes the datum with nothing new
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        if (load) begin
            state_d    = FULL;
            ptr_d      = pick;
            out_data_d = mux_d;
            out_sel_d  = pick;
        end else if (can_load) begin
            state_d = EMPTY;
        end
    end
`ifdef MUX_ARB_BURST_EN
    // burst tracking: count consecutive grants to the same index, up to four
    always_comb begin
        cnt_d   = cnt_q;
        burst_d = burst_q;
        if (load) begin
            burst_d = 1'b1;
            cnt_d   = (burst_q && pick == ptr_q && cnt_q != 2'd3) ? cnt_q + 2'd1 : 2'd0;
        end else if (state_q == EMPTY && req == 4'b0000) begin
            burst_d = 1'b0;
            cnt_d   = 2'd0;
        end
    end
`endif
    // state registers; ptr resets to 3 so requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            ptr_q      <= 2'd3;
            out_data_q <= '0;
            out_sel_q  <= '0;
`ifdef MUX_ARB_BURST_EN
            cnt_q      <= 2'd0;
            burst_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
`ifdef MUX_ARB_BURST_EN
            cnt_q      <= cnt_d;
            burst_q    <= burst_d;
`endif
        end
    end
endmodule

// File: tb/tb_mux_arb_4.sv
// tb_mux_arb_4: scoreboard bench for mux_arb_4 (directed vectors; burst expectations under MUX_ARB_BURST_EN)
module tb_mux_arb_4;
    logic clk = 1'b0;
    logic rst, out_ready, out_valid;
    logic [3:0] req, gnt, d0, d1, d2, d3, out_data;
    logic [1:0] out_sel;
    logic [5:0] exp_q[$];
    int n_cmp = 0, n_bad = 0;

    mux_arb_4 #(.W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .out_ready(out_ready), .gnt(gnt), .out_valid(out_valid),
        .out_data(out_data), .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // monitor: a transfer happens at the edge following a negedge with valid and ready
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_transfer", {26'd0, out_sel, out_data}, 32'hFFFF_FFFF);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                chk("out_sel", {30'd0, out_sel}, {30'd0, e[5:4]});
                chk("out_data", {28'd0, out_data}, {28'd0, e[3:0]});
            end
        end
    end

    initial begin
        logic [3:0] g;
        rst = 1'b1; req = '0; out_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        step(); step();
        rst = 1'b0;
        // idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_gnt", {28'd0, gnt}, 32'd0);
            chk("idle_data", {28'd0, out_data}, 32'd0);
            chk("idle_sel", {30'd0, out_sel}, 32'd0);
            step();
        end
        // single request
        req = 4'b0100; d2 = 4'hC; out_ready = 1'b1;
        @(negedge clk);
        chk("single_gnt", {28'd0, gnt}, 32'h4);
        exp_q.push_back({2'd2, 4'hC});
        step();
        req = 4'b0000;
        @(negedge clk);
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        step();
        @(negedge clk);
        chk("single_drop", {31'd0, out_valid}, 32'd0);
        // all requesting
        pulse_reset();
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
`ifndef MUX_ARB_BURST_EN
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            g = 4'b0001 << (i % 4);
            chk("rr_gnt", {28'd0, gnt}, {28'd0, g});
            exp_q.push_back({2'(i % 4), 4'hA + 4'(i % 4)});
            step();
        end
`else
        req = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            logic [1:0] s;
            s = (i >= 4 && i < 8) ? 2'd1 : 2'd0;
            @(negedge clk);
            g = 4'b0001 << s;
            chk("burst_gnt", {28'd0, gnt}, {28'd0, g});
            exp_q.push_back({s, s == 2'd1 ? 4'hB : 4'hA});
            step();
        end
`endif
        req = 4'b0000;
        step(); step();
        // backpressure
        pulse_reset();
        req = 4'b0001;
        @(negedge clk);
        chk("bp_first_gnt", {28'd0, gnt}, 32'h1);
        exp_q.push_back({2'd0, 4'hA});
        step();
        out_ready = 1'b0; req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_gnt", {28'd0, gnt}, 32'd0);
            chk("bp_data", {28'd0, out_data}, 32'hA);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
`ifndef MUX_ARB_BURST_EN
        chk("bp_next_gnt", {28'd0, gnt}, 32'h2);
        exp_q.push_back({2'd1, 4'hB});
`else
        chk("bp_next_gnt", {28'd0, gnt}, 32'h1);
        exp_q.push_back({2'd0, 4'hA});
`endif
        step();
        req = 4'b0000;
        step(); step();
        // reset mid-operation with a pending datum
        req = 4'b0100;
        @(negedge clk);
        chk("mid_gnt", {28'd0, gnt}, 32'h4);
        step();
        req = 4'b1111; rst = 1'b1;
        @(negedge clk);
        chk("mid_sel", {30'd0, out_sel}, 32'd2);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_next_gnt", {28'd0, gnt}, 32'h1);
        exp_q.push_back({2'd0, 4'hA});
        step();
        req = 4'b0000;
        step(); step(); step();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
